mips_run_ctrl: RTL and testbench
================================

Name: mips_run_ctrl

Overview:
Execution and program-load controller for the single-cycle MIPS core on the board. Generates the core's clock-enable in halt, single-step and free-run modes, stops on a PC breakpoint, and writes instruction words arriving on GPIO into instruction memory through a 4-phase strobe/ack handshake. Sits between the button debouncer/switches and the CPU core; its state drives the status LEDs.

Parameters:
AW, 8, instruction-memory word-address width
RUN_DIV, 25000000, core clocks per CPU_EN pulse in free-run (>=2)
SYNC_STAGES, 2, flops in GPIO_STB synchroniser (>=2)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
BTN_STEP  in  1  debounced one-cycle pulse: single step
BTN_RUN  in  1  debounced one-cycle pulse: toggle run/halt
LOAD_EN  in  1  switch level: program-load mode
GPIO_DATA  in  32  instruction word from external host
GPIO_STB  in  1  asynchronous host strobe, data valid while high
PC  in  32  current core PC (byte address)
BRK_EN  in  1  breakpoint enable
BRK_ADDR  in  AW  breakpoint word address
CPU_EN  out  1  core clock-enable, one-cycle pulses
IM_WE  out  1  instruction-memory write strobe
IM_ADDR  out  AW  instruction-memory write word address
IM_WDATA  out  32  instruction-memory write data
GPIO_ACK  out  1  handshake acknowledge to host
STATE  out  2  0=HALT 1=STEP 2=RUN 3=LOAD
HALT_BRK  out  1  sticky: halted by breakpoint

Behaviour:
- Reset (RST low, async): state HALT; CPU_EN, IM_WE, GPIO_ACK, HALT_BRK = 0; IM_ADDR, IM_WDATA, divider, synchroniser = 0.
- Priority each cycle: LOAD_EN > BTN_RUN > BTN_STEP.
- HALT: CPU_EN=0. LOAD_EN=1 -> LOAD. BTN_RUN -> RUN (divider cleared). BTN_STEP -> STEP. BTN_RUN and BTN_STEP same cycle -> RUN.
- STEP: lasts exactly one cycle, CPU_EN=1 in that cycle, then HALT. Breakpoint ignored (allows stepping off a breakpoint).
- RUN: divider counts 0..RUN_DIV-1, wraps. CPU_EN=1 only in the cycle divider==RUN_DIV-1. BTN_RUN -> HALT next cycle, no further pulse. BTN_STEP ignored.
- Breakpoint: in RUN, if BRK_EN=1 and PC[AW+1:2]==BRK_ADDR in the cycle a pulse would issue, pulse suppressed, state -> HALT, HALT_BRK=1. Instruction at BRK_ADDR is not executed.
- HALT_BRK cleared on entry to RUN, STEP or LOAD.
- LOAD_EN=1 in any state -> LOAD next cycle; pending pulse dropped, divider cleared. CPU_EN=0 throughout LOAD.
- LOAD entry: write pointer = 0.
- GPIO_STB passed through SYNC_STAGES flops; GPIO_DATA sampled only on synchronised rising edge (data stable by then per handshake).
- On synced rising edge in LOAD: IM_WDATA <= GPIO_DATA, IM_ADDR <= pointer, IM_WE=1 for exactly one cycle; next cycle pointer+1 (mod 2^AW, 2^AW-1 wraps to 0) and GPIO_ACK=1.
- GPIO_ACK held until synced strobe low, then cleared same cycle it is seen low. New rising edge accepted only when GPIO_ACK=0.
- Strobe edges outside LOAD ignored; no write, no ack.
- LOAD_EN=0 -> HALT next cycle; GPIO_ACK cleared, in-progress handshake abandoned; written words retained.
- IM_WE never asserted outside LOAD; CPU_EN and IM_WE never high together.

Test Plan:
- Reset mid-RUN with RUN_DIV=4: RST low for 1 cycle -> STATE=0, CPU_EN=0 immediately, no pulse for 10 cycles after release.
- HALT, BTN_STEP pulse -> STATE=1 for one cycle, exactly one CPU_EN pulse, then STATE=0; BTN_STEP+BTN_RUN together -> STATE=2.
- RUN_DIV=4, BTN_RUN -> CPU_EN pulse every 4th cycle over 20 cycles (5 pulses); BTN_RUN again -> no further pulses.
- BRK_EN=1, BRK_ADDR=3, PC sweeps 0x0,0x4,0x8,0xC -> pulses at PC 0,4,8 only, STATE=0, HALT_BRK=1; BTN_STEP -> one pulse, HALT_BRK=0.
- LOAD_EN=1, host sends 0x20080005, 0x20090007, 0x01095020 with full 4-phase handshake -> IM_WE at addresses 0,1,2 with those data, GPIO_ACK follows each strobe, CPU_EN stays 0.
- AW=2, load 5 words -> 5th writes address 0 (wrap); drop LOAD_EN while GPIO_ACK=1 -> ACK=0, STATE=0 next cycle, no extra IM_WE.

Source files
------------

// File: rtl/mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl
//
// Execution and program-load controller for the single-cycle MIPS core.
// Produces the core clock-enable in halt, single-step and free-run modes,
// stops the core on a PC breakpoint, and writes instruction words received
// from an external host over GPIO into instruction memory using a 4-phase
// strobe/acknowledge handshake.
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   btn_step_i    debounced one-cycle pulse: execute one instruction
//   btn_run_i     debounced one-cycle pulse: toggle run/halt
//   load_en_i     switch level: program-load mode (highest priority)
//   gpio_data_i   instruction word from host, valid while strobe is high
//   gpio_stb_i    asynchronous host strobe
//   pc_i          current core PC (byte address)
//   brk_en_i      breakpoint enable
//   brk_addr_i    breakpoint word address
//   cpu_en_o      core clock-enable, one-cycle pulses
//   im_we_o       instruction-memory write strobe (one cycle per word)
//   im_addr_o     instruction-memory write word address
//   im_wdata_o    instruction-memory write data
//   gpio_ack_o    handshake acknowledge to host
//   state_o       0=HALT 1=STEP 2=RUN 3=LOAD
//   halt_brk_o    sticky: core was halted by the breakpoint
// -----------------------------------------------------------------------------
module mips_run_ctrl #(
  parameter int unsigned AW          = 8,
  parameter int unsigned RUN_DIV     = 25000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          btn_step_i,
  input  logic          btn_run_i,
  input  logic          load_en_i,
  input  logic [31:0]   gpio_data_i,
  input  logic          gpio_stb_i,
  input  logic [31:0]   pc_i,
  input  logic          brk_en_i,
  input  logic [AW-1:0] brk_addr_i,
  output logic          cpu_en_o,
  output logic          im_we_o,
  output logic [AW-1:0] im_addr_o,
  output logic [31:0]   im_wdata_o,
  output logic          gpio_ack_o,
  output logic [1:0]    state_o,
  output logic          halt_brk_o
);

  // Divider width; RUN_DIV >= 2 so $clog2 is at least 1.
  localparam int unsigned DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2,
    ST_LOAD = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic                 halt_brk_q, halt_brk_d;
  logic                 cpu_en;

  logic [SYNC_STAGES-1:0] stb_sync_q;
  logic                 stb_prev_q;
  logic                 stb_s;
  logic                 stb_rise;

  logic [AW-1:0]        ptr_q, ptr_d;
  logic                 im_we_q, im_we_d;
  logic [AW-1:0]        im_addr_q, im_addr_d;
  logic [31:0]          im_wdata_q, im_wdata_d;
  logic                 ack_q, ack_d;

  logic                 pulse_slot;
  logic                 brk_hit;
  logic                 stay_load;
  logic                 accept;

  // ---------------------------------------------------------------------------
  // Strobe synchroniser. stb_prev_q is one extra flop behind the last
  // synchroniser stage so edge detection only looks at settled values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_sync_q <= '0;
      stb_prev_q <= 1'b0;
    end else begin
      stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], gpio_stb_i};
      stb_prev_q <= stb_sync_q[SYNC_STAGES-1];
    end
  end

  assign stb_s    = stb_sync_q[SYNC_STAGES-1];
  assign stb_rise = stb_s & ~stb_prev_q;

  // ---------------------------------------------------------------------------
  // Run-control FSM
  // ---------------------------------------------------------------------------
  assign pulse_slot = (state_q == ST_RUN) && (div_q == DIV_LAST);
  assign brk_hit    = brk_en_i && (pc_i[AW+1:2] == brk_addr_i);

  always_comb begin
    state_d    = state_q;
    cpu_en     = 1'b0;
    halt_brk_d = halt_brk_q;

    unique case (state_q)
      ST_HALT: begin
        // Run wins over step when both buttons arrive together.
        if (btn_run_i) begin
          state_d = ST_RUN;
        end else if (btn_step_i) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        // The breakpoint is deliberately not checked here so the user can
        // step off the instruction the core stopped on.
        cpu_en  = 1'b1;
        state_d = ST_HALT;
      end
      ST_RUN: begin
        if (btn_run_i) begin
          state_d = ST_HALT;
        end else if (pulse_slot) begin
          if (brk_hit) begin
            // Swallow the pulse: the breakpoint instruction stays unexecuted.
            state_d    = ST_HALT;
            halt_brk_d = 1'b1;
          end else begin
            cpu_en = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (!load_en_i) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase

    // Load mode overrides everything, including a pulse due this cycle.
    if (load_en_i) begin
      state_d    = ST_LOAD;
      cpu_en     = 1'b0;
      halt_brk_d = halt_brk_q;
    end

    if ((state_d != state_q) && (state_d != ST_HALT)) begin
      halt_brk_d = 1'b0;
    end
  end

  // Divider only advances while staying in RUN; any entry starts it from 0.
  always_comb begin
    div_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Program-load handshake
  //   rise seen      -> capture word, IM_WE next cycle
  //   IM_WE cycle    -> bump pointer, raise ACK
  //   strobe low     -> drop ACK, ready for the next word
  // ---------------------------------------------------------------------------
  assign stay_load = (state_q == ST_LOAD) && load_en_i;
  assign accept    = stay_load && stb_rise && !ack_q && !im_we_q;

  always_comb begin
    im_we_d    = accept;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    ack_d      = ack_q;
    ptr_d      = ptr_q;

    if (accept) begin
      im_addr_d  = ptr_q;
      im_wdata_d = gpio_data_i;
    end

    if (!stay_load) begin
      // Leaving (or not in) LOAD abandons any handshake in progress.
      ack_d = 1'b0;
    end else if (im_we_q) begin
      ack_d = 1'b1;
    end else if (ack_q && !stb_s) begin
      ack_d = 1'b0;
    end

    if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
      ptr_d = '0;
    end else if (stay_load && im_we_q) begin
      ptr_d = ptr_q + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_HALT;
      div_q      <= '0;
      halt_brk_q <= 1'b0;
      ptr_q      <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      halt_brk_q <= halt_brk_d;
      ptr_q      <= ptr_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      ack_q      <= ack_d;
    end
  end

  assign cpu_en_o   = cpu_en;
  assign im_we_o    = im_we_q;
  assign im_addr_o  = im_addr_q;
  assign im_wdata_o = im_wdata_q;
  assign gpio_ack_o = ack_q;
  assign state_o    = state_q;
  assign halt_brk_o = halt_brk_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
module tb_mips_run_ctrl;

  localparam int AW      = 2;
  localparam int RUN_DIV = 4;
  localparam int SS      = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_step = 1'b0;
  logic          btn_run = 1'b0;
  logic          load_en = 1'b0;
  logic [31:0]   gpio_data = '0;
  logic          gpio_stb = 1'b0;
  logic [31:0]   pc = '0;
  logic          brk_en = 1'b0;
  logic [AW-1:0] brk_addr = '0;
  logic          cpu_en;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          gpio_ack;
  logic [1:0]    state;
  logic          halt_brk;

  always #5 clk = ~clk;

  mips_run_ctrl #(.AW(AW), .RUN_DIV(RUN_DIV), .SYNC_STAGES(SS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .btn_step_i(btn_step), .btn_run_i(btn_run),
    .load_en_i(load_en), .gpio_data_i(gpio_data), .gpio_stb_i(gpio_stb),
    .pc_i(pc), .brk_en_i(brk_en), .brk_addr_i(brk_addr),
    .cpu_en_o(cpu_en), .im_we_o(im_we), .im_addr_o(im_addr),
    .im_wdata_o(im_wdata), .gpio_ack_o(gpio_ack), .state_o(state),
    .halt_brk_o(halt_brk)
  );

  // Reference model: mode as an integer, time spent in RUN as a plain count,
  // the synchroniser as a delay line of raw strobe samples.
  int          m_mode;
  int          m_runcnt;
  int          m_ptr;
  bit          m_brk;
  bit          m_we;
  bit          m_ack;
  int          m_addr;
  logic [31:0] m_data;
  bit          hist[$];

  int          n_vec = 0;
  int          n_err = 0;
  bit          core_sim = 1'b0;
  int          pulses = 0;
  int          writes = 0;
  logic [31:0] mem [4];

  function automatic void model_reset();
    m_mode = 0; m_runcnt = 0; m_ptr = 0; m_brk = 0; m_we = 0; m_ack = 0;
    m_addr = 0; m_data = '0;
    hist.delete();
    for (int i = 0; i <= SS; i++) hist.push_back(1'b0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: compare DUT against model at the falling edge, advance
  // the model to the next cycle, then step past the rising edge.
  task automatic cycle();
    bit slot, hit, ecpu, synced, prev, rise, stay, acc, nbrk, nack;
    int nmode, nptr;
    @(negedge clk);
    slot = (m_mode == 2) && ((m_runcnt % RUN_DIV) == RUN_DIV - 1);
    hit  = brk_en && (((pc >> 2) & ((1 << AW) - 1)) == 32'(brk_addr));
    ecpu = !load_en && ((m_mode == 1) || (slot && !btn_run && !hit));
    chk("state",    32'(state),    32'(m_mode));
    chk("cpu_en",   32'(cpu_en),   32'(ecpu));
    chk("im_we",    32'(im_we),    32'(m_we));
    chk("im_addr",  32'(im_addr),  32'(m_addr));
    chk("im_wdata", im_wdata,      m_data);
    chk("gpio_ack", 32'(gpio_ack), 32'(m_ack));
    chk("halt_brk", 32'(halt_brk), 32'(m_brk));
    if (ecpu) pulses++;
    if (im_we) begin
      writes++;
      mem[im_addr] = im_wdata;
    end

    if (load_en) nmode = 3;
    else begin
      case (m_mode)
        0: nmode = btn_run ? 2 : (btn_step ? 1 : 0);
        2: nmode = (btn_run || (slot && hit)) ? 0 : 2;
        default: nmode = 0;
      endcase
    end
    nbrk = m_brk;
    if (m_mode == 2 && !load_en && !btn_run && slot && hit) nbrk = 1;
    if (nmode != m_mode && nmode != 0) nbrk = 0;

    synced = hist[SS-1];
    prev   = hist[SS];
    rise   = synced && !prev;
    stay   = (m_mode == 3) && load_en;
    acc    = stay && rise && !m_ack && !m_we;
    if (!stay) nack = 0;
    else if (m_we) nack = 1;
    else if (m_ack && !synced) nack = 0;
    else nack = m_ack;
    nptr = m_ptr;
    if (nmode == 3 && m_mode != 3) nptr = 0;
    else if (stay && m_we) nptr = (m_ptr + 1) % (1 << AW);
    if (acc) begin
      m_addr = m_ptr;
      m_data = gpio_data;
    end
    m_we  = acc;
    m_ack = nack;
    m_ptr = nptr;
    m_runcnt = (nmode == 2 && m_mode == 2) ? m_runcnt + 1 : 0;
    m_mode = nmode;
    m_brk  = nbrk;
    hist.push_front(gpio_stb);
    void'(hist.pop_back());

    @(posedge clk);
    #1;
    btn_step = 1'b0;
    btn_run  = 1'b0;
    if (core_sim && ecpu) pc = pc + 32'd4;
  endtask

  // Host side of the 4-phase handshake, bounded so a silent DUT cannot hang.
  task automatic send_word(input logic [31:0] w);
    int t;
    gpio_data = w;
    gpio_stb  = 1'b1;
    t = 0;
    while (!gpio_ack && t < 20) begin cycle(); t++; end
    chk("ack_rise_in_time", 32'(t < 20), 32'd1);
    gpio_stb  = 1'b0;
    gpio_data = $urandom;
    t = 0;
    while (gpio_ack && t < 20) begin cycle(); t++; end
    chk("ack_fall_in_time", 32'(t < 20), 32'd1);
    cycle();
  endtask

  initial begin
    // Power-on reset
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",  32'(state),    32'd0);
    chk("rst_cpu_en", 32'(cpu_en),   32'd0);
    chk("rst_ack",    32'(gpio_ack), 32'd0);
    rst_n = 1'b1;
    repeat (3) cycle();

    // Single step, then step+run together
    pulses = 0;
    btn_step = 1'b1; cycle();
    repeat (3) cycle();
    chk("step_pulses", 32'(pulses), 32'd1);
    btn_step = 1'b1; btn_run = 1'b1; cycle();
    chk("step_run_to_run", 32'(state), 32'd2);
    btn_run = 1'b1; cycle();
    cycle();

    // Free-run: pulse every RUN_DIV cycles, none after halting
    btn_run = 1'b1; cycle();
    pulses = 0;
    repeat (20) cycle();
    chk("run_pulses_20", 32'(pulses), 32'd5);
    btn_run = 1'b1; cycle();
    pulses = 0;
    repeat (12) cycle();
    chk("halted_pulses", 32'(pulses), 32'd0);

    // Reset in the middle of RUN
    btn_run = 1'b1; cycle();
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_state",  32'(state),  32'd0);
    chk("midrst_cpu_en", 32'(cpu_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    pulses = 0;
    repeat (10) cycle();
    chk("midrst_no_pulse", 32'(pulses), 32'd0);

    // Breakpoint at word 3 with the core advancing PC on every pulse
    brk_en = 1'b1; brk_addr = 2'd3; pc = 32'h0; core_sim = 1'b1;
    pulses = 0;
    btn_run = 1'b1; cycle();
    repeat (20) cycle();
    chk("brk_pulses",   32'(pulses),   32'd3);
    chk("brk_pc",       pc,            32'h0000_000C);
    chk("brk_halt_brk", 32'(halt_brk), 32'd1);
    pulses = 0;
    btn_step = 1'b1; cycle();
    repeat (2) cycle();
    chk("brk_step_pulse", 32'(pulses),   32'd1);
    chk("brk_step_clear", 32'(halt_brk), 32'd0);
    core_sim = 1'b0; brk_en = 1'b0;

    // Strobe outside LOAD is ignored
    writes = 0;
    gpio_data = 32'hCAFE_F00D; gpio_stb = 1'b1;
    repeat (6) cycle();
    gpio_stb = 1'b0;
    repeat (4) cycle();
    chk("no_write_outside_load", 32'(writes), 32'd0);

    // Program load, including pointer wrap with AW=2
    load_en = 1'b1; cycle();
    writes = 0;
    send_word(32'h2008_0005);
    send_word(32'h2009_0007);
    send_word(32'h0109_5020);
    chk("load3_writes", 32'(writes), 32'd3);
    chk("mem0", mem[0], 32'h2008_0005);
    chk("mem1", mem[1], 32'h2009_0007);
    chk("mem2", mem[2], 32'h0109_5020);
    send_word(32'hDEAD_BEEF);
    send_word(32'h1234_5678);
    chk("load5_writes", 32'(writes), 32'd5);
    chk("mem3", mem[3], 32'hDEAD_BEEF);
    chk("mem0_wrap", mem[0], 32'h1234_5678);

    // Drop LOAD_EN while ACK is high
    writes = 0;
    gpio_data = 32'hA5A5_5A5A; gpio_stb = 1'b1;
    for (int t = 0; t < 20 && !gpio_ack; t++) cycle();
    chk("drop_ack_high", 32'(gpio_ack), 32'd1);
    load_en = 1'b0; cycle();
    chk("drop_ack_low", 32'(gpio_ack), 32'd0);
    chk("drop_state",   32'(state),    32'd0);
    repeat (4) cycle();
    gpio_stb = 1'b0;
    repeat (3) cycle();
    chk("drop_one_write", 32'(writes), 32'd1);

    // Randomised mix of buttons, load mode, breakpoints and host traffic
    core_sim = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      btn_step = ($urandom % 10) == 0;
      btn_run  = ($urandom % 20) == 0;
      if (($urandom % 120) == 0) load_en = ~load_en;
      if (($urandom % 40) == 0) begin
        brk_en   = $urandom;
        brk_addr = $urandom;
      end
      if (($urandom % 60) == 0) pc = $urandom;
      if (!gpio_stb && !gpio_ack && ($urandom % 4) == 0) begin
        gpio_stb  = 1'b1;
        gpio_data = $urandom;
      end else if (gpio_stb && (gpio_ack || ($urandom % 32) == 0)) begin
        gpio_stb = 1'b0;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
